memory_bus_arbiter: RTL and testbench

//  Shares the single memory_bus port between two requesters: the CPU core and a DMA/loader master.

---
 rtl/memory_bus_pkg.sv | 32 +++
 rtl/memory_bus_arbiter_if.sv | 51 +++++
 rtl/arbiter_rr2.sv | 57 +++++
 rtl/memory_bus_arbiter.sv | 112 +++++++++++
 tb/tb_memory_bus_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the memory bus arbiter and its environment.
package memory_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    typedef logic [1:0] bank_t;

    localparam bank_t BANK_RAM    = 2'b00;
    localparam bank_t BANK_ROM    = 2'b01;
    localparam bank_t BANK_PERIPH = 2'b10;
    localparam bank_t BANK_BRAM   = 2'b11;

    // Bank select lives in the top two address bits; decode happens downstream.
    function automatic bank_t bank_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: 2];
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Requester-side handshakes and the memory_bus port of the arbiter, in one bundle.
interface memory_bus_arbiter_if;
    import memory_bus_pkg::*;

    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_data_in;
    logic [MASK_W-1:0] cpu_write_mask;
    logic [DATA_W-1:0] cpu_data_out;
    logic              cpu_ready;

    logic              dma_req;
    logic              dma_write;
    logic [ADDR_W-1:0] dma_address;
    logic [DATA_W-1:0] dma_data_in;
    logic [MASK_W-1:0] dma_write_mask;
    logic [DATA_W-1:0] dma_data_out;
    logic              dma_ready;

    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_data_in;
    logic [MASK_W-1:0] bus_write_mask;
    logic              bus_write_enable;
    logic              bus_enable;
    logic [DATA_W-1:0] bus_data_out;
    logic              busy;

    // Arbiter's view.
    modport master (
        input  cpu_req, cpu_write, cpu_address, cpu_data_in, cpu_write_mask,
        output cpu_data_out, cpu_ready,
        input  dma_req, dma_write, dma_address, dma_data_in, dma_write_mask,
        output dma_data_out, dma_ready,
        output bus_address, bus_data_in, bus_write_mask, bus_write_enable, bus_enable,
        input  bus_data_out,
        output busy
    );

    // Requesters' and memory's view.
    modport slave (
        output cpu_req, cpu_write, cpu_address, cpu_data_in, cpu_write_mask,
        input  cpu_data_out, cpu_ready,
        output dma_req, dma_write, dma_address, dma_data_in, dma_write_mask,
        input  dma_data_out, dma_ready,
        input  bus_address, bus_data_in, bus_write_mask, bus_write_enable, bus_enable,
        output bus_data_out,
        input  busy
    );

endinterface

// File: rtl/arbiter_rr2.sv
// Two-way round-robin picker (bit0 = CPU, bit1 = DMA) with a CPU burst allowance.
// Latency: grant is combinational from the reqs; state advances on grant_strobe.
// Backpressure: none; the caller decides when a grant is taken via grant_strobe.
module arbiter_rr2
    import memory_bus_pkg::*;
#(
    parameter int CPU_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       grant_strobe,
    output logic [1:0] grant
);

    localparam logic [3:0] BURST_MAX = 4'(CPU_BURST);

    owner_t     last_owner;
    logic [3:0] burst_cnt;

    always_comb begin
        grant = 2'b00;
        if (cpu_req && dma_req) begin
            // CPU may keep the bus for a bounded run even while DMA waits.
            if (last_owner == OWNER_CPU && burst_cnt < BURST_MAX)
                grant = 2'b01;
            else if (last_owner == OWNER_CPU)
                grant = 2'b10;
            else
                grant = 2'b01;
        end else if (cpu_req) begin
            grant = 2'b01;
        end else if (dma_req) begin
            grant = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWNER_DMA;
            burst_cnt  <= 4'd0;
        end else if (grant_strobe && grant[1]) begin
            last_owner <= OWNER_DMA;
            burst_cnt  <= 4'd0;
        end else if (grant_strobe && grant[0]) begin
            last_owner <= OWNER_CPU;
            if (!dma_req)
                burst_cnt <= 4'd0;
            else if (burst_cnt < BURST_MAX)
                burst_cnt <= burst_cnt + 4'd1;
        end else if (!dma_req) begin
            burst_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares memory_bus between CPU and DMA: address phase, READ_WAIT wait cycles (reads), ready pulse.
// Latency: write 3 cycles, read 3+READ_WAIT cycles from req in IDLE to the one-cycle ready.
// Backpressure: requesters hold req until ready; fields are sampled only at grant.
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter int READ_WAIT = 1,
    parameter int CPU_BURST = 4
) (
    input  logic                 raw_clk,
    input  logic                 reset,
    memory_bus_arbiter_if.master bus
);

    localparam logic [1:0] WAIT_LAST = 2'(READ_WAIT - 1);

    state_t     state;
    owner_t     owner;
    logic [1:0] wait_cnt;
    logic [1:0] grant;
    logic       any_req;
    logic       grant_strobe;

    assign any_req      = bus.cpu_req | bus.dma_req;
    assign grant_strobe = any_req && (state == IDLE || state == DONE);

    arbiter_rr2 #(
        .CPU_BURST(CPU_BURST)
    ) u_rr (
        .clk         (raw_clk),
        .rst_n       (reset),
        .cpu_req     (bus.cpu_req),
        .dma_req     (bus.dma_req),
        .grant_strobe(grant_strobe),
        .grant       (grant)
    );

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            owner                <= OWNER_CPU;
            wait_cnt             <= 2'd0;
            bus.bus_address      <= '0;
            bus.bus_data_in      <= '0;
            bus.bus_write_mask   <= '0;
            bus.bus_write_enable <= 1'b0;
            bus.bus_enable       <= 1'b0;
            bus.busy             <= 1'b0;
            bus.cpu_data_out     <= '0;
            bus.cpu_ready        <= 1'b0;
            bus.dma_data_out     <= '0;
            bus.dma_ready        <= 1'b0;
        end else begin
            bus.cpu_ready <= 1'b0;
            bus.dma_ready <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (any_req) begin
                        state          <= ACCESS;
                        bus.busy       <= 1'b1;
                        bus.bus_enable <= 1'b1;
                        if (grant[1]) begin
                            owner                <= OWNER_DMA;
                            bus.bus_address      <= bus.dma_address;
                            bus.bus_data_in      <= bus.dma_data_in;
                            bus.bus_write_mask   <= bus.dma_write_mask;
                            bus.bus_write_enable <= bus.dma_write;
                        end else begin
                            owner                <= OWNER_CPU;
                            bus.bus_address      <= bus.cpu_address;
                            bus.bus_data_in      <= bus.cpu_data_in;
                            bus.bus_write_mask   <= bus.cpu_write_mask;
                            bus.bus_write_enable <= bus.cpu_write;
                        end
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Enables are single-cycle: peripheral reads have side effects.
                    bus.bus_enable       <= 1'b0;
                    bus.bus_write_enable <= 1'b0;
                    if (bus.bus_write_enable) begin
                        state <= DONE;
                        if (owner == OWNER_DMA) bus.dma_ready <= 1'b1;
                        else                    bus.cpu_ready <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_LAST;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= DONE;
                        if (owner == OWNER_DMA) begin
                            bus.dma_data_out <= bus.bus_data_out;
                            bus.dma_ready    <= 1'b1;
                        end else begin
                            bus.cpu_data_out <= bus.bus_data_out;
                            bus.cpu_ready    <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench: two arbiter instances (READ_WAIT 1 and 2) against a simple banked memory model.
module tb_memory_bus_arbiter;
    import memory_bus_pkg::*;

    logic raw_clk = 1'b0;
    logic reset;
    always #5 raw_clk = ~raw_clk;

    memory_bus_arbiter_if bi();
    memory_bus_arbiter_if bi2();

    memory_bus_arbiter #(.READ_WAIT(1), .CPU_BURST(4)) dut (
        .raw_clk(raw_clk), .reset(reset), .bus(bi)
    );
    memory_bus_arbiter #(.READ_WAIT(2), .CPU_BURST(4)) dut2 (
        .raw_clk(raw_clk), .reset(reset), .bus(bi2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory: ROM bank ignores writes; unread cycles return a poison word.
    logic [31:0] mem [0:16383];
    logic [31:0] rd1, rd2a, rd2b;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge raw_clk) begin
        rd1 <= 32'h0BAD0BAD;
        if (bi.bus_enable) begin
            if (bi.bus_write_enable) begin
                if (bank_of(bi.bus_address) != BANK_ROM)
                    mem[bi.bus_address[15:2]] <= merge(mem[bi.bus_address[15:2]], bi.bus_data_in, bi.bus_write_mask);
            end else begin
                rd1 <= mem[bi.bus_address[15:2]];
            end
        end
    end
    assign bi.bus_data_out = rd1;

    always @(posedge raw_clk) begin
        rd2a <= (bi2.bus_enable && !bi2.bus_write_enable) ? mem[bi2.bus_address[15:2]] : 32'h0BAD0BAD;
        rd2b <= rd2a;
    end
    assign bi2.bus_data_out = rd2b;

    task automatic do_access(
        input  logic        is_dma, input logic wr, input logic [15:0] addr,
        input  logic [31:0] wdata,  input logic [3:0] mask,
        output int rdy_cyc, output int en_n, output int we_n, output int other_n,
        output logic [31:0] rdata, output logic [15:0] cap_addr,
        output logic [31:0] cap_data, output logic [3:0] cap_mask);
        @(negedge raw_clk);
        if (is_dma) begin
            bi.dma_req = 1'b1; bi.dma_write = wr; bi.dma_address = addr;
            bi.dma_data_in = wdata; bi.dma_write_mask = mask;
        end else begin
            bi.cpu_req = 1'b1; bi.cpu_write = wr; bi.cpu_address = addr;
            bi.cpu_data_in = wdata; bi.cpu_write_mask = mask;
        end
        rdy_cyc = 0; en_n = 0; we_n = 0; other_n = 0; rdata = '0;
        cap_addr = '0; cap_data = '0; cap_mask = '0;
        for (int c = 2; c <= 30; c++) begin
            @(negedge raw_clk);
            if (bi.bus_enable) begin
                en_n++;
                cap_addr = bi.bus_address; cap_data = bi.bus_data_in; cap_mask = bi.bus_write_mask;
            end
            if (bi.bus_write_enable) we_n++;
            if (is_dma ? bi.cpu_ready : bi.dma_ready) other_n++;
            if (is_dma ? bi.dma_ready : bi.cpu_ready) begin
                rdy_cyc = c;
                rdata = is_dma ? bi.dma_data_out : bi.cpu_data_out;
                break;
            end
        end
        if (is_dma) bi.dma_req = 1'b0;
        else        bi.cpu_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rc, en, we, oth, n, rdy_seen;
        logic [31:0] rdata, cdata;
        logic [15:0] caddr;
        logic [3:0]  cmask;
        byte seq [10];
        int  cyc [10];
        string exp_seq;

        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[16'h4010 >> 2] = 32'hDEADBEEF;
        mem[16'h4020 >> 2] = 32'h11112222;
        mem[16'h0020 >> 2] = 32'hAAAAAAAA;
        mem[16'h8000 >> 2] = 32'hCAFE0001;

        reset = 1'b0;
        bi.cpu_req = 0; bi.cpu_write = 0; bi.cpu_address = 0; bi.cpu_data_in = 0; bi.cpu_write_mask = 0;
        bi.dma_req = 0; bi.dma_write = 0; bi.dma_address = 0; bi.dma_data_in = 0; bi.dma_write_mask = 0;
        bi2.cpu_req = 0; bi2.cpu_write = 0; bi2.cpu_address = 0; bi2.cpu_data_in = 0; bi2.cpu_write_mask = 0;
        bi2.dma_req = 0; bi2.dma_write = 0; bi2.dma_address = 0; bi2.dma_data_in = 0; bi2.dma_write_mask = 0;
        repeat (3) @(negedge raw_clk);

        check("rst_busy",   32'(bi.busy), 0);
        check("rst_en",     32'(bi.bus_enable), 0);
        check("rst_addr",   32'(bi.bus_address), 0);
        check("rst_cpu_rdy", 32'(bi.cpu_ready), 0);
        check("rst_dma_rdy", 32'(bi.dma_ready), 0);
        reset = 1'b1;
        @(negedge raw_clk);

        // 1: CPU ROM read
        do_access(1'b0, 1'b0, 16'h4010, 32'h0, 4'h0, rc, en, we, oth, rdata, caddr, cdata, cmask);
        check("t1_ready_cycle", rc, 4);
        check("t1_en_pulses", en, 1);
        check("t1_we_pulses", we, 0);
        check("t1_addr", 32'(caddr), 32'h4010);
        check("t1_data", rdata, 32'hDEADBEEF);
        check("t1_dma_rdy", oth, 0);

        // 2: DMA masked write, then CPU read-back
        do_access(1'b1, 1'b1, 16'h0020, 32'h12345678, 4'b0011, rc, en, we, oth, rdata, caddr, cdata, cmask);
        check("t2_ready_cycle", rc, 3);
        check("t2_we_pulses", we, 1);
        check("t2_en_pulses", en, 1);
        check("t2_addr", 32'(caddr), 32'h0020);
        check("t2_wdata", cdata, 32'h12345678);
        check("t2_mask", 32'(cmask), 32'h3);
        check("t2_cpu_rdy", oth, 0);
        do_access(1'b0, 1'b0, 16'h0020, 32'h0, 4'h0, rc, en, we, oth, rdata, caddr, cdata, cmask);
        check("t2_readback", rdata, 32'hAAAA5678);

        // 5: address change after grant must not disturb the access
        @(negedge raw_clk);
        bi.cpu_req = 1'b1; bi.cpu_write = 1'b0; bi.cpu_address = 16'h4010;
        @(negedge raw_clk);
        bi.cpu_address = 16'h4020;
        check("t5_addr_access", 32'(bi.bus_address), 32'h4010);
        @(negedge raw_clk);
        check("t5_addr_wait", 32'(bi.bus_address), 32'h4010);
        check("t5_en_wait", 32'(bi.bus_enable), 0);
        @(negedge raw_clk);
        check("t5_ready", 32'(bi.cpu_ready), 1);
        check("t5_data", bi.cpu_data_out, 32'hDEADBEEF);
        bi.cpu_req = 1'b0;
        repeat (2) @(negedge raw_clk);

        // 3: both requesting continuously
        bi.cpu_req = 1'b1; bi.cpu_write = 1'b0; bi.cpu_address = 16'h4010;
        bi.dma_req = 1'b1; bi.dma_write = 1'b0; bi.dma_address = 16'h0020;
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            @(negedge raw_clk);
            if (bi.cpu_ready) begin seq[n] = "C"; cyc[n] = c; n++; end
            else if (bi.dma_ready) begin seq[n] = "D"; cyc[n] = c; n++; end
        end
        bi.cpu_req = 1'b0; bi.dma_req = 1'b0;
        check("t3_count", n, 10);
        exp_seq = "CCCCDCCCCD";
        for (int i = 0; i < n; i++) check("t3_order", 32'(seq[i]), 32'(exp_seq[i]));
        for (int i = 1; i < n; i++) check("t3_spacing", cyc[i] - cyc[i-1], 3);
        check("t3_dma_data", bi.dma_data_out, 32'hAAAA5678);
        repeat (2) @(negedge raw_clk);

        // 4: reset in the WAIT phase of a CPU read
        bi.cpu_req = 1'b1; bi.cpu_write = 1'b0; bi.cpu_address = 16'h4010;
        repeat (2) @(negedge raw_clk);
        check("t4_busy_before", 32'(bi.busy), 1);
        #2 reset = 1'b0;
        #1;
        check("t4_busy", 32'(bi.busy), 0);
        check("t4_addr", 32'(bi.bus_address), 0);
        check("t4_cpu_data", bi.cpu_data_out, 0);
        check("t4_dma_data", bi.dma_data_out, 0);
        check("t4_en", 32'(bi.bus_enable), 0);
        bi.cpu_req = 1'b0;
        rdy_seen = 0;
        repeat (3) begin
            @(negedge raw_clk);
            if (bi.cpu_ready) rdy_seen++;
        end
        check("t4_no_ready", rdy_seen, 0);
        reset = 1'b1;
        @(negedge raw_clk);
        do_access(1'b0, 1'b0, 16'h4010, 32'h0, 4'h0, rc, en, we, oth, rdata, caddr, cdata, cmask);
        check("t4_after_cycle", rc, 4);
        check("t4_after_data", rdata, 32'hDEADBEEF);

        // 6: peripheral read with READ_WAIT=2 on the second instance
        @(negedge raw_clk);
        bi2.cpu_req = 1'b1; bi2.cpu_write = 1'b0; bi2.cpu_address = 16'h8000;
        en = 0; rc = 0;
        for (int c = 2; c <= 20; c++) begin
            @(negedge raw_clk);
            if (bi2.bus_enable) en++;
            if (c >= 2 && c <= 4) check("t6_addr_stable", 32'(bi2.bus_address), 32'h8000);
            if (bi2.cpu_ready) begin
                rc = c;
                rdata = bi2.cpu_data_out;
                break;
            end
        end
        bi2.cpu_req = 1'b0;
        check("t6_en_pulses", en, 1);
        check("t6_ready_cycle", rc, 5);
        check("t6_data", rdata, 32'hCAFE0001);

        repeat (2) @(negedge raw_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
